// File: rtl/matrix_operand_loader_pkg.sv
// matrix_operand_loader_pkg
// Shared definitions for the matrix operand loader:
//   - state encoding of the loader FSM
//   - header word field positions and widths
//   - DIM / DATA_W default values
//   - header decode and legality helpers
package matrix_operand_loader_pkg;

    localparam int DIM_DEF    = 8;
    localparam int DATA_W_DEF = 32;

    // Header word layout: [7:0] rows_a, [15:8] cols_a, [23:16] cols_b, [31:24] unused.
    localparam int HDR_FLD_W  = 8;
    localparam int HDR_RA_LSB = 0;
    localparam int HDR_CA_LSB = 8;
    localparam int HDR_CB_LSB = 16;
    localparam int HDR_USED_W = 24;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        RUN    = 3'd3,
        WAIT   = 3'd4,
        DONE   = 3'd5
    } state_t;

    typedef struct packed {
        logic [HDR_FLD_W-1:0] cols_b;
        logic [HDR_FLD_W-1:0] cols_a;
        logic [HDR_FLD_W-1:0] rows_a;
    } dims_t;

    function automatic dims_t hdr_dims(input logic [HDR_USED_W-1:0] hdr);
        dims_t d;
        d.rows_a = hdr[HDR_RA_LSB +: HDR_FLD_W];
        d.cols_a = hdr[HDR_CA_LSB +: HDR_FLD_W];
        d.cols_b = hdr[HDR_CB_LSB +: HDR_FLD_W];
        return d;
    endfunction

    // Every dimension must lie in 1..dim.
    function automatic logic hdr_legal(input logic [HDR_USED_W-1:0] hdr, input int dim);
        dims_t d;
        d = hdr_dims(hdr);
        return (d.rows_a != '0) && (int'(d.rows_a) <= dim) &&
               (d.cols_a != '0) && (int'(d.cols_a) <= dim) &&
               (d.cols_b != '0) && (int'(d.cols_b) <= dim);
    endfunction

endpackage

// File: rtl/matrix_operand_loader_index.sv
// matrix_index_counter
// Row/column walker over a rows x cols region in row-major order.
// Column advances on each step; on the last column it wraps and the row
// advances. On the very last element both wrap to zero so the same
// instance can be reused for the next phase without an explicit clear.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   clear        force row=col=0
//   step         advance by one element
//   rows, cols   region size (1..2**W-1)
//   row, col     current element position
//   last         current position is the final element of the region
module matrix_index_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         step,
    input  logic [W-1:0] rows,
    input  logic [W-1:0] cols,
    output logic [W-1:0] row,
    output logic [W-1:0] col,
    output logic         last
);

    logic col_end;
    logic row_end;

    assign col_end = (col == cols - W'(1));
    assign row_end = (row == rows - W'(1));
    assign last    = col_end && row_end;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            row <= '0;
            col <= '0;
        end else if (step) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + W'(1);
            end else begin
                col <= col + W'(1);
            end
        end
    end

endmodule

// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader
// Upstream feeder for the matrix multiplier. Consumes a valid/ready word
// stream: one header word (dims), A row-major, then B row-major. Fills the
// A/B operand buffers, then holds mult_enable until the multiplier has armed
// (mult_done low) and finished (mult_done high again), then pulses op_done.
//
// Build option: MATRIX_LOADER_CLEAR_EN -- when defined, accepting a legal
// header zeroes both buffers so elements outside the loaded region read 0.
// Otherwise unloaded elements keep earlier contents until reset.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_valid/in_ready stream handshake, transfer when both high at clk rise
//   in_data           header or element word
//   mat_a, mat_b      operand buffers, element [r][c] at index r*DIM+c
//   op_rows_a         rows of A
//   op_cols_a         cols of A (= rows of B)
//   op_cols_b         cols of B
//   mult_enable       multiplier enable, high in RUN and WAIT
//   mult_done         multiplier done/idle flag
//   op_done           one-cycle completion pulse
//   hdr_err           sticky illegal-header flag, cleared only by reset
//   busy              high whenever not IDLE
module matrix_operand_loader
    import matrix_operand_loader_pkg::*;
#(
    parameter int DIM    = DIM_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic [DIM*DIM*DATA_W-1:0]  mat_a,
    output logic [DIM*DIM*DATA_W-1:0]  mat_b,
    output logic [7:0]                 op_rows_a,
    output logic [7:0]                 op_cols_a,
    output logic [7:0]                 op_cols_b,
    output logic                       mult_enable,
    input  logic                       mult_done,
    output logic                       op_done,
    output logic                       hdr_err,
    output logic                       busy
);

    localparam int NELEM = DIM * DIM;
    localparam int AW    = (NELEM > 1) ? $clog2(NELEM) : 1;

    state_t state;
    state_t state_n;

    dims_t  dims_q;
    dims_t  hdr_d;
    logic   xfer;
    logic   hdr_ok;
    logic   hdr_accept;
    logic   hdr_bad;
    logic   in_a;
    logic   in_b;

    logic [HDR_FLD_W-1:0] cnt_rows;
    logic [HDR_FLD_W-1:0] cnt_cols;
    logic [HDR_FLD_W-1:0] row;
    logic [HDR_FLD_W-1:0] col;
    logic                 last;
    logic [AW-1:0]        addr;

    logic [NELEM-1:0][DATA_W-1:0] buf_a;
    logic [NELEM-1:0][DATA_W-1:0] buf_b;

    assign xfer       = in_valid && in_ready;
    assign hdr_d      = hdr_dims(in_data[HDR_USED_W-1:0]);
    assign hdr_ok     = hdr_legal(in_data[HDR_USED_W-1:0], DIM);
    assign hdr_accept = xfer && (state == IDLE) && hdr_ok;
    assign hdr_bad    = xfer && (state == IDLE) && !hdr_ok;
    assign in_a       = xfer && (state == LOAD_A);
    assign in_b       = xfer && (state == LOAD_B);

    // B is cols_a rows by cols_b columns; A is rows_a by cols_a.
    assign cnt_rows = (state == LOAD_B) ? dims_q.cols_a : dims_q.rows_a;
    assign cnt_cols = (state == LOAD_B) ? dims_q.cols_b : dims_q.cols_a;

    matrix_index_counter #(.W(HDR_FLD_W)) u_idx (
        .clk   (clk),
        .reset (reset),
        .clear (hdr_accept),
        .step  (in_a || in_b),
        .rows  (cnt_rows),
        .cols  (cnt_cols),
        .row   (row),
        .col   (col),
        .last  (last)
    );

    // Buffers are always DIM wide per row, independent of the loaded cols.
    assign addr = AW'(32'(row) * DIM + 32'(col));

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (hdr_accept)   state_n = LOAD_A;
            LOAD_A:  if (in_a && last) state_n = LOAD_B;
            LOAD_B:  if (in_b && last) state_n = RUN;
            // mult_done is high while the multiplier is idle, so first wait
            // for it to drop (armed) before treating a high level as done.
            RUN:     if (!mult_done)   state_n = WAIT;
            WAIT:    if (mult_done)    state_n = DONE;
            DONE:                      state_n = IDLE;
            default:                   state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            mult_enable <= 1'b0;
            op_done     <= 1'b0;
            busy        <= 1'b0;
            hdr_err     <= 1'b0;
            dims_q      <= '0;
        end else begin
            state       <= state_n;
            in_ready    <= (state_n == IDLE) || (state_n == LOAD_A) || (state_n == LOAD_B);
            mult_enable <= (state_n == RUN) || (state_n == WAIT);
            op_done     <= (state_n == DONE);
            busy        <= (state_n != IDLE);
            if (hdr_bad)
                hdr_err <= 1'b1;
            if (hdr_accept)
                dims_q  <= hdr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_a <= '0;
            buf_b <= '0;
        end else begin
`ifdef MATRIX_LOADER_CLEAR_EN
            if (hdr_accept) begin
                buf_a <= '0;
                buf_b <= '0;
            end
`endif
            if (in_a)
                buf_a[addr] <= in_data;
            if (in_b)
                buf_b[addr] <= in_data;
        end
    end

    assign mat_a     = buf_a;
    assign mat_b     = buf_b;
    assign op_rows_a = dims_q.rows_a;
    assign op_cols_a = dims_q.cols_a;
    assign op_cols_b = dims_q.cols_b;

endmodule
